// File: rtl/sta_tile_scheduler.sv
// sta_tile_scheduler
//   Sequences the STA compute pipeline (STA, output coordinator, requant,
//   maxpool) over one conv layer. Output tiles of SA_N x SA_N are walked in
//   raster order. For each tile the scheduler:
//     - strobes load_bias once,
//     - issues k_len operand beats,
//     - strobes done,
//     - waits out a guard window,
//     - waits for the pipeline to report idle,
//     - then advances to the next tile.
//
// Optional feature: define STA_SCHED_PERF_EN to add the perf_tiles and
// perf_stall counters.
//
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   start           1-cycle pulse to begin a layer (ignored while busy)
//   abort           synchronous: drop current layer, return to IDLE
//   out_rows/cols   output feature-map size, latched on start
//   k_len           reduction beats per tile, latched on start
//   stall           pipeline stall, freezes the scheduler
//   sta_ctrl_idle   pipeline idle flag
//   busy            layer in progress
//   layer_done      1-cycle pulse when the last tile has drained
//   pos_row/pos_col base coordinate of the current tile
//   load_bias       bias-load strobe
//   feed_valid      operand beat feed_k must be presented this cycle
//   feed_k          beat index 0..k_len-1
//   done            end-of-tile strobe to the output coordinator
//   perf_tiles      (STA_SCHED_PERF_EN) tiles completed, saturating
//   perf_stall      (STA_SCHED_PERF_EN) stalled busy cycles, saturating
//
// Strobe semantics: load_bias, feed_valid and done are consumed on cycles
// where stall is 0. A stalled cycle leaves every output unchanged, so the
// same strobe/beat is offered again on the next cycle. There is no
// back-pressure other than stall and no ready signal.
module sta_tile_scheduler #(
    parameter int MAX_N      = 64,
    parameter int N_BITS     = $clog2(MAX_N),
    parameter int SA_N       = 4,
    parameter int MAX_K      = 1024,
    parameter int K_BITS     = $clog2(MAX_K + 1),
    parameter int IDLE_GUARD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [N_BITS-1:0] out_rows,
    input  logic [N_BITS-1:0] out_cols,
    input  logic [K_BITS-1:0] k_len,
    input  logic              stall,
    input  logic              sta_ctrl_idle,
    output logic              busy,
    output logic              layer_done,
    output logic [N_BITS-1:0] pos_row,
    output logic [N_BITS-1:0] pos_col,
    output logic              load_bias,
    output logic              feed_valid,
    output logic [K_BITS-1:0] feed_k,
`ifdef STA_SCHED_PERF_EN
    output logic [15:0]       perf_tiles,
    output logic [31:0]       perf_stall,
`endif
    output logic              done
);

    localparam int G_BITS = $clog2(IDLE_GUARD + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_BIAS, S_FEED, S_DONE, S_GUARD, S_WAIT_IDLE, S_NEXT
    } state_t;

    // state_q is the FSM state that debug checkers bind to.
    state_t              state_q, state_d;
    logic [N_BITS-1:0]   rows_q, rows_d, cols_q, cols_d;
    logic [K_BITS-1:0]   klen_q, klen_d, k_q, k_d;
    logic [G_BITS-1:0]   guard_q, guard_d;
    logic [N_BITS-1:0]   pos_row_q, pos_row_d, pos_col_q, pos_col_d;
    logic                busy_q, busy_d, layer_done_q, layer_done_d;
    logic                load_bias_q, load_bias_d, feed_valid_q, feed_valid_d;
    logic                done_q, done_d;

    // One extra bit so that coordinate + SA_N never wraps.
    logic [N_BITS:0]     col_ext, row_ext;
    logic                last_beat;
    logic                accept_start;

    assign col_ext      = {1'b0, pos_col_q} + (N_BITS+1)'(SA_N);
    assign row_ext      = {1'b0, pos_row_q} + (N_BITS+1)'(SA_N);
    assign last_beat    = (k_q == klen_q - K_BITS'(1));
    // A start that coincides with layer_done belongs to the finishing layer
    // and is dropped.
    assign accept_start = (state_q == S_IDLE) && start && !layer_done_q && !abort;

    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        cols_d       = cols_q;
        klen_d       = klen_q;
        k_d          = k_q;
        guard_d      = guard_q;
        pos_row_d    = pos_row_q;
        pos_col_d    = pos_col_q;
        layer_done_d = 1'b0;

        if (abort) begin
            // Coordinates are held so software can see where the layer stopped.
            state_d = S_IDLE;
            k_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_start) begin
                        rows_d    = out_rows;
                        cols_d    = out_cols;
                        klen_d    = k_len;
                        pos_row_d = '0;
                        pos_col_d = '0;
                        if (out_rows == '0 || out_cols == '0 || k_len == '0) begin
                            layer_done_d = 1'b1;
                        end else begin
                            state_d = S_BIAS;
                        end
                    end
                end
                S_BIAS: begin
                    if (!stall) begin
                        state_d = S_FEED;
                        k_d     = '0;
                    end
                end
                S_FEED: begin
                    if (!stall) begin
                        if (last_beat) begin
                            state_d = S_DONE;
                            k_d     = '0;
                        end else begin
                            k_d = k_q + K_BITS'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (!stall) begin
                        state_d = S_GUARD;
                        guard_d = G_BITS'(IDLE_GUARD);
                    end
                end
                S_GUARD: begin
                    // Exactly IDLE_GUARD cycles are spent here.
                    if (!stall) begin
                        if (guard_q <= G_BITS'(1)) begin
                            state_d = S_WAIT_IDLE;
                        end
                        guard_d = (guard_q != '0) ? guard_q - G_BITS'(1) : '0;
                    end
                end
                S_WAIT_IDLE: begin
                    if (sta_ctrl_idle) begin
                        state_d = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (!stall) begin
                        if (col_ext >= {1'b0, cols_q}) begin
                            if (row_ext >= {1'b0, rows_q}) begin
                                // Last tile: hold pos and finish the layer.
                                state_d      = S_IDLE;
                                layer_done_d = 1'b1;
                            end else begin
                                pos_col_d = '0;
                                pos_row_d = row_ext[N_BITS-1:0];
                                state_d   = S_BIAS;
                            end
                        end else begin
                            pos_col_d = col_ext[N_BITS-1:0];
                            state_d   = S_BIAS;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Outputs are registered copies of the next state. A frozen state
        // therefore keeps them frozen. busy also covers a real layer's
        // layer_done cycle, but not the zero-size pulse issued from IDLE.
        busy_d       = (state_d != S_IDLE) || (layer_done_d && state_q != S_IDLE);
        load_bias_d  = (state_d == S_BIAS);
        feed_valid_d = (state_d == S_FEED);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rows_q       <= '0;
            cols_q       <= '0;
            klen_q       <= '0;
            k_q          <= '0;
            guard_q      <= '0;
            pos_row_q    <= '0;
            pos_col_q    <= '0;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b0;
            load_bias_q  <= 1'b0;
            feed_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            klen_q       <= klen_d;
            k_q          <= k_d;
            guard_q      <= guard_d;
            pos_row_q    <= pos_row_d;
            pos_col_q    <= pos_col_d;
            busy_q       <= busy_d;
            layer_done_q <= layer_done_d;
            load_bias_q  <= load_bias_d;
            feed_valid_q <= feed_valid_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign layer_done = layer_done_q;
    assign pos_row    = pos_row_q;
    assign pos_col    = pos_col_q;
    assign load_bias  = load_bias_q;
    assign feed_valid = feed_valid_q;
    assign feed_k     = k_q;
    assign done       = done_q;

`ifdef STA_SCHED_PERF_EN
    logic [15:0] perf_tiles_q, perf_tiles_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_tiles_d = perf_tiles_q;
        perf_stall_d = perf_stall_q;
        if (accept_start) begin
            perf_tiles_d = '0;
            perf_stall_d = '0;
        end else begin
            // A tile counts as completed when its done strobe is consumed.
            if (state_q == S_DONE && !stall && !abort && !(&perf_tiles_q)) begin
                perf_tiles_d = perf_tiles_q + 16'd1;
            end
            if (stall && busy_q && !(&perf_stall_q)) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_tiles_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_tiles_q <= perf_tiles_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_tiles = perf_tiles_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_sta_tile_scheduler.sv
// Testbench for sta_tile_scheduler.
// Expected tile coordinates are pushed to exp_q when a layer is started and
// popped when the scheduler strobes load_bias. Beat indices, strobe spacing,
// busy and layer_done are checked cycle by cycle.
module tb_sta_tile_scheduler;

  localparam int N_BITS     = 6;
  localparam int K_BITS     = 11;
  localparam int SA_N       = 4;
  localparam int IDLE_GUARD = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, abort, stall, sta_ctrl_idle;
  logic [N_BITS-1:0] out_rows, out_cols;
  logic [K_BITS-1:0] k_len;
  logic              busy, layer_done, load_bias, feed_valid, done;
  logic [N_BITS-1:0] pos_row, pos_col;
  logic [K_BITS-1:0] feed_k;
`ifdef STA_SCHED_PERF_EN
  logic [15:0]       perf_tiles;
  logic [31:0]       perf_stall;
`endif

  int errors = 0;
  int checks = 0;
  logic [2*N_BITS-1:0] exp_q[$];

  sta_tile_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .out_rows     (out_rows),
    .out_cols     (out_cols),
    .k_len        (k_len),
    .stall        (stall),
    .sta_ctrl_idle(sta_ctrl_idle),
    .busy         (busy),
    .layer_done   (layer_done),
    .pos_row      (pos_row),
    .pos_col      (pos_col),
    .load_bias    (load_bias),
    .feed_valid   (feed_valid),
    .feed_k       (feed_k),
`ifdef STA_SCHED_PERF_EN
    .perf_tiles   (perf_tiles),
    .perf_stall   (perf_stall),
`endif
    .done         (done)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver: call just after a negedge. The scheduler sees start at the
  // next posedge.
  task automatic do_start(input int rows, input int cols, input int k);
    out_rows = N_BITS'(rows);
    out_cols = N_BITS'(cols);
    k_len    = K_BITS'(k);
    start    = 1'b1;
    for (int r = 0; r < rows; r += SA_N)
      for (int c = 0; c < cols; c += SA_N)
        exp_q.push_back({N_BITS'(r), N_BITS'(c)});
  endtask

  // Runs one layer to layer_done (or to abort), checking every cycle.
  // Stall is applied on the first tile at beat stall_beat for stall_len
  // cycles. sta_ctrl_idle is held low for idle_hold cycles past the guard
  // window after the first tile. abort fires on tile abort_tile at beat 1.
  task automatic run_layer(input int k, input int stall_beat, input int stall_len,
                           input int idle_hold, input int abort_tile, output bit aborted);
    int cyc = 0, tile = 0, beat = 0, lb_cyc = 0, done_cyc = 0;
    int stall_left = 0, idle_left = 0, gap_extra = 0, tile_stall = 0;
    bit stall_used = 0, finished = 0;
    logic [2*N_BITS-1:0] cur = '0, got, exp;
    aborted = 1'b0;
    while (!finished && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      abort = 1'b0;
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else if (stall_len > 0 && !stall_used && tile == 1 && feed_valid === 1'b1 &&
                   feed_k === K_BITS'(stall_beat)) begin
        stall      = 1'b1;
        stall_left = stall_len - 1;
        stall_used = 1'b1;
        tile_stall = stall_len;
      end else begin
        stall = 1'b0;
      end
      if (idle_left > 0) begin
        sta_ctrl_idle = 1'b0;
        idle_left--;
      end else begin
        sta_ctrl_idle = 1'b1;
      end

      if (cyc == 1) begin
        checks++;
        if (load_bias !== 1'b1) begin
          errors++;
          $display("FAIL start_to_bias: load_bias=%b required 1", load_bias);
        end
      end

      if (layer_done === 1'b1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_at_layer_done: busy=%b required 1", busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
          errors++;
          $display("FAIL tiles_issued: %0d tiles missing, required 0", exp_q.size());
        end
        checks++;
        if (cyc - done_cyc != 7) begin
          errors++;
          $display("FAIL done_to_layer_done: gap=%0d required 7", cyc - done_cyc);
        end
        finished = 1'b1;
      end else begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_during_layer: cycle %0d busy=%b required 1", cyc, busy);
        end
        if (load_bias === 1'b1 && !stall) begin
          tile++;
          got = {pos_row, pos_col};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL tile_pos: extra tile at (%0d,%0d) required none", pos_row, pos_col);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL tile_pos: (%0d,%0d) required (%0d,%0d)", pos_row, pos_col,
                       exp[2*N_BITS-1:N_BITS], exp[N_BITS-1:0]);
            end
          end
          if (tile > 1) begin
            checks++;
            if (cyc - done_cyc != 7 + gap_extra) begin
              errors++;
              $display("FAIL done_to_next_bias: gap=%0d required %0d", cyc - done_cyc, 7 + gap_extra);
            end
          end
          gap_extra = 0;
          cur       = got;
          beat      = 0;
          lb_cyc    = cyc;
        end else if (tile > 0) begin
          checks++;
          if ({pos_row, pos_col} !== cur) begin
            errors++;
            $display("FAIL pos_stable: (%0d,%0d) required (%0d,%0d)", pos_row, pos_col,
                     cur[2*N_BITS-1:N_BITS], cur[N_BITS-1:0]);
          end
        end
        if (feed_valid === 1'b1 && !stall) begin
          checks++;
          if (feed_k !== K_BITS'(beat)) begin
            errors++;
            $display("FAIL feed_k: %0d required %0d", feed_k, beat);
          end
          beat++;
          if (abort_tile == tile && beat == 2) begin
            abort    = 1'b1;
            aborted  = 1'b1;
            finished = 1'b1;
          end
        end
        if (done === 1'b1 && !stall) begin
          checks++;
          if (beat != k) begin
            errors++;
            $display("FAIL beats_per_tile: %0d required %0d", beat, k);
          end
          checks++;
          if (cyc - lb_cyc != k + 1 + tile_stall) begin
            errors++;
            $display("FAIL bias_to_done: gap=%0d required %0d", cyc - lb_cyc, k + 1 + tile_stall);
          end
          tile_stall = 0;
          done_cyc   = cyc;
          if (idle_hold > 0 && tile == 1) begin
            idle_left = IDLE_GUARD + idle_hold;
            gap_extra = idle_hold;
          end
        end
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL layer_timeout: no layer_done within %0d cycles", cyc);
    end
    stall         = 1'b0;
    sta_ctrl_idle = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 0; abort = 0; stall = 0; sta_ctrl_idle = 1;
    out_rows = '0; out_cols = '0; k_len = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, layer_done, load_bias, feed_valid, done, pos_row, pos_col, feed_k} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b ld=%b lb=%b fv=%b done=%b row=%0d col=%0d k=%0d required all 0",
               busy, layer_done, load_bias, feed_valid, done, pos_row, pos_col, feed_k);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit ab;
    do_start(8, 8, 3);
    run_layer(3, 0, 0, 0, 0, ab);
    @(negedge clk);
    checks++;
    if (layer_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_layer_done: ld=%b busy=%b required 0 0", layer_done, busy);
    end
`ifdef STA_SCHED_PERF_EN
    checks++;
    if (perf_tiles !== 16'd4 || perf_stall !== 32'd0) begin
      errors++;
      $display("FAIL perf_basic: tiles=%0d stall=%0d required 4 0", perf_tiles, perf_stall);
    end
`endif
  endtask

  task automatic test_stall();
    bit ab;
    do_start(8, 8, 3);
    run_layer(3, 1, 5, 0, 0, ab);
    @(negedge clk);
`ifdef STA_SCHED_PERF_EN
    checks++;
    if (perf_tiles !== 16'd4 || perf_stall !== 32'd5) begin
      errors++;
      $display("FAIL perf_stall: tiles=%0d stall=%0d required 4 5", perf_tiles, perf_stall);
    end
`endif
  endtask

  task automatic test_zero_dim();
    out_rows = 6'd8; out_cols = 6'd8; k_len = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (layer_done !== 1'b1 || busy !== 1'b0 || load_bias !== 1'b0) begin
      errors++;
      $display("FAIL zero_dim_done: ld=%b busy=%b lb=%b required 1 0 0", layer_done, busy, load_bias);
    end
    // A start in the layer_done cycle must be ignored.
    k_len = K_BITS'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (layer_done !== 1'b0 || busy !== 1'b0 || load_bias !== 1'b0 || feed_valid !== 1'b0) begin
      errors++;
      $display("FAIL start_at_layer_done: ld=%b busy=%b lb=%b fv=%b required 0 0 0 0",
               layer_done, busy, load_bias, feed_valid);
    end
    out_cols = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (layer_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_cols_done: ld=%b busy=%b required 1 0", layer_done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_idle_wait();
    bit ab;
    do_start(8, 8, 3);
    run_layer(3, 0, 0, 20, 0, ab);
    @(negedge clk);
  endtask

  task automatic test_edge_abort();
    bit ab;
    do_start(4, 6, 3);
    run_layer(3, 0, 0, 0, 2, ab);
    checks++;
    if (ab !== 1'b1) begin
      errors++;
      $display("FAIL abort_reached: aborted=%b required 1", ab);
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 0 || load_bias !== 0 || feed_valid !== 0 || done !== 0 || layer_done !== 0) begin
      errors++;
      $display("FAIL abort_outputs: busy=%b lb=%b fv=%b done=%b ld=%b required 0 0 0 0 0",
               busy, load_bias, feed_valid, done, layer_done);
    end
    checks++;
    if (pos_row !== 6'd0 || pos_col !== 6'd4) begin
      errors++;
      $display("FAIL abort_pos_held: (%0d,%0d) required (0,4)", pos_row, pos_col);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (layer_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_quiet: ld=%b busy=%b required 0 0", layer_done, busy);
      end
    end
    exp_q.delete();
    do_start(4, 6, 3);
    run_layer(3, 0, 0, 0, 0, ab);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit ab;
    for (int i = 0; i < 4; i++) begin
      int r = $urandom_range(1, 13);
      int c = $urandom_range(1, 13);
      int k = $urandom_range(1, 5);
      do_start(r, c, k);
      run_layer(k, 0, 0, 0, 0, ab);
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    out_rows = 6'd8; out_cols = 6'd8; k_len = K_BITS'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (feed_valid !== 1'b1 || feed_k !== '0) begin
      errors++;
      $display("FAIL pre_reset_feed: fv=%b k=%0d required 1 0", feed_valid, feed_k);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, layer_done, load_bias, feed_valid, done, pos_row, pos_col, feed_k} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b ld=%b lb=%b fv=%b done=%b row=%0d col=%0d k=%0d required all 0",
               busy, layer_done, load_bias, feed_valid, done, pos_row, pos_col, feed_k);
    end
`ifdef STA_SCHED_PERF_EN
    checks++;
    if (perf_tiles !== '0 || perf_stall !== '0) begin
      errors++;
      $display("FAIL async_reset_perf: tiles=%0d stall=%0d required 0 0", perf_tiles, perf_stall);
    end
`endif
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_dim();
    test_idle_wait();
    test_edge_abort();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
